// File: rtl/sw_target_feeder.sv
// Front-end controller for the Smith-Waterman PE array: buffers a target,
// bursts it into PE[0] and returns the unbiased best score.
module sw_target_feeder #(
    parameter int SCORE_WIDTH = 12,
    parameter int MAX_LEN     = 256,
    parameter int N_PE        = 64,
    parameter int TIMEOUT     = N_PE + 4,
    localparam int LW         = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   t_valid,
    output logic                   t_ready,
    input  logic [1:0]             t_base,
    input  logic                   t_last,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic [SCORE_WIDTH-1:0] pe_High_in,
    input  logic                   pe_vld_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-2:0] res_score,
    output logic [LW-1:0]          res_len,
    output logic                   res_err,
    output logic                   busy
);

    localparam int SW = SCORE_WIDTH;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] ZERO  = {1'b1, {(SW-1){1'b0}}};
    localparam logic [LW-1:0] MAX_V = LW'(MAX_LEN);
    localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        WAIT_RES,
        RESULT
    } state_e;

    logic [1:0] mem [MAX_LEN];

    state_e          state_q, state_d;
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ovf_q, ovf_d;
    logic            prime_q, prime_d;
    logic            pe_en_q, pe_en_d;
    logic [1:0]      pe_data_q, pe_data_d;
    logic            res_valid_q, res_valid_d;
    logic [SW-2:0]   res_score_q, res_score_d;
    logic [LW-1:0]   res_len_q, res_len_d;
    logic            res_err_q, res_err_d;

    logic            beat;
    logic            mem_we;
    logic [SW-1:0]   unbias;
    logic            unbias_msb_unused;

    assign t_ready = (state_q == LOAD) & rst;
    assign beat    = t_valid & t_ready;
    assign mem_we  = beat & (wr_ptr_q != MAX_V);
    assign unbias  = pe_High_in - ZERO;
    assign unbias_msb_unused = unbias[SW-1];

    assign pe_en     = pe_en_q;
    assign pe_data   = pe_data_q;
    assign pe_M      = ZERO;
    assign pe_I      = ZERO;
    assign pe_High   = ZERO;
    assign res_valid = res_valid_q;
    assign res_score = res_score_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != LOAD);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= t_base;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        timer_d     = timer_q;
        ovf_d       = ovf_q;
        prime_d     = prime_q;
        pe_en_d     = 1'b0;
        pe_data_d   = pe_data_q;
        res_valid_d = res_valid_q;
        res_score_d = res_score_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        unique case (state_q)
            LOAD: begin
                if (beat) begin
                    if (wr_ptr_q == MAX_V) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + LW'(1);
                    end
                    if (t_last) begin
                        len_d    = wr_ptr_d;
                        rd_ptr_d = '0;
                        prime_d  = 1'b0;
                        state_d  = STREAM;
                    end
                end
            end
            STREAM: begin
                // One idle cycle before the burst; the burst itself never gaps.
                if (!prime_q) begin
                    prime_d = 1'b1;
                end else if (rd_ptr_q != len_q) begin
                    pe_en_d   = 1'b1;
                    pe_data_d = mem[rd_ptr_q[AW-1:0]];
                    rd_ptr_d  = rd_ptr_q + LW'(1);
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (pe_vld_in) begin
                    res_score_d = unbias[SW-2:0];
                    res_len_d   = len_q;
                    res_err_d   = ovf_q;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else if (timer_q == TO_V) begin
                    res_score_d = '0;
                    res_len_d   = len_q;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    len_d       = '0;
                    timer_d     = '0;
                    ovf_d       = 1'b0;
                    prime_d     = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            timer_q     <= '0;
            ovf_q       <= 1'b0;
            prime_q     <= 1'b0;
            pe_en_q     <= 1'b0;
            pe_data_q   <= 2'b00;
            res_valid_q <= 1'b0;
            res_score_q <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            timer_q     <= timer_d;
            ovf_q       <= ovf_d;
            prime_q     <= prime_d;
            pe_en_q     <= pe_en_d;
            pe_data_q   <= pe_data_d;
            res_valid_q <= res_valid_d;
            res_score_q <= res_score_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
        end
    end

endmodule
